fir_mac_core: RTL and testbench
===============================

Name: fir_mac_core

Overview:
- Sequential FIR compute engine that sits directly downstream of the AXI/stream interface block.
- Accepts one input sample per handshake and keeps the last Tap_Num samples in an internal history register file.
- Reads coefficients from the tap SRAM port one tap per cycle and accumulates one output per sample.
- Presents each result on a valid/ready output with a last flag and a running count of completed outputs.

Parameters:
- pADDR_WIDTH, 12, tap SRAM byte-address width.
- pDATA_WIDTH, 32, sample, coefficient and result width.
- Tap_Num, 11, number of taps; legal range 2..16.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  engine enable. When low, the whole engine stalls (all state held).
- clr  in  1  synchronous clear of the history and num_vld_ops. Asserted at frame start.
- s_valid  in  1  input sample valid.
- s_data  in  pDATA_WIDTH  input sample, signed.
- s_last  in  1  marks the last sample of the frame.
- s_ready  out  1  core can accept a sample.
- tap_ren  out  1  tap SRAM read enable.
- tap_addr  out  pADDR_WIDTH  tap byte address, equal to {k,2'b00}.
- tap_rdata  in  pDATA_WIDTH  coefficient, valid 1 cycle after tap_ren.
- y_valid  out  1  result valid.
- y_data  out  pDATA_WIDTH  FIR result.
- y_last  out  1  result belongs to the last sample.
- y_ready  in  1  downstream accepts the result.
- num_vld_ops  out  32  count of results accepted since reset or clr.
- busy  out  1  high in MAC or OUT.

Behaviour:
- Reset values:
  - state = IDLE.
  - history all 0, acc 0, k 0, num_vld_ops 0.
  - s_ready 1, tap_ren 0, tap_addr 0, y_valid 0, y_data 0, y_last 0, busy 0.
- Stall: every register update is qualified by en. With en low, outputs hold their values and s_ready is forced to 0.
- State IDLE:
  - s_ready = en.
  - On s_valid & s_ready: x[0]<=s_data and x[i]<=x[i-1] for i=1..Tap_Num-1; last_q<=s_last; acc<=0; k<=0; go to MAC.
- State MAC (Tap_Num+1 active cycles):
  - Cycle c in 0..Tap_Num-1: tap_ren=1, tap_addr={c,2'b00}, and x[c] is captured into a one-stage delay.
  - Cycles c in 1..Tap_Num: acc <= acc + tap_rdata * x_delayed.
  - Product is signed 32x32; the low pDATA_WIDTH bits are kept and added modulo 2^32 (wrap-around).
  - After the final add, go to OUT.
- State OUT:
  - y_valid=1, y_data=acc, y_last=last_q.
  - Outputs are held stable until y_ready.
  - On y_valid & y_ready: num_vld_ops++, go to IDLE, and y_valid falls in the next cycle.
- Latency (en held high): an accept in cycle T gives y_valid in cycle T+Tap_Num+2.
- Throughput: one sample per Tap_Num+3 cycles when y_ready is held high.
- Backpressure: no new sample is accepted while in MAC or OUT (s_ready=0).
- clr:
  - Has priority over the handshake.
  - In IDLE it zeroes the history and num_vld_ops.
  - In MAC or OUT it also aborts to IDLE with y_valid=0 and no count increment.
- num_vld_ops wraps from 0xFFFFFFFF to 0.
- An asynchronous reset mid-operation returns everything to the reset values immediately. No partial result is emitted.
- tap_addr never exceeds {Tap_Num-1,2'b00}.

Optional Feature:
- Macro: FIR_SAT_EN.
- Defined:
  - acc is 2*pDATA_WIDTH bits signed, and the full product is accumulated.
  - y_data is acc clamped to [0x80000000, 0x7FFFFFFF].
- Undefined: 32-bit wrap-around accumulation as specified above.
- Latency and handshake are identical in both builds.

Test Plan:
1. Impulse and ramp:
   - Setup: Tap_Num=11, coefficients h[k]=k+1, inputs x=1,2,3 with y_ready=1.
   - Required: y_data=1,4,10; each y_valid appears 13 cycles after its accept; num_vld_ops=3.
2. Backpressure:
   - Stimulus: hold y_ready=0 for 20 cycles in OUT.
   - Required: y_data and y_valid stable; s_ready=0; no count change.
   - Then y_ready=1 for one cycle: count increments by 1 and the core returns to IDLE.
3. Stall:
   - Stimulus: deassert en for 5 cycles mid-MAC.
   - Required: tap_ren/tap_addr frozen; the result still equals the ungated result; latency grows by 5.
4. Last and clr:
   - Stimulus: the third sample carries s_last=1.
   - Required: its result has y_last=1.
   - Then pulse clr in IDLE: num_vld_ops=0; the next input x=5 gives y_data=5.
5. Wrap and saturation:
   - Stimulus: h[0]=0x7FFFFFFF, others 0, x=2.
   - Required without FIR_SAT_EN: y_data=0xFFFFFFFE.
   - Required with FIR_SAT_EN: y_data=0x7FFFFFFF.
6. Reset mid-MAC:
   - Stimulus: drop rst_n in MAC cycle 4.
   - Required: all outputs take their reset values asynchronously.
   - After release: a sample x=1 with h[k]=k+1 gives y_data=1 (history cleared).

Source files
------------

// File: rtl/fir_mac_core.sv
// Sequential FIR engine: one sample in, one coefficient read and MAC per cycle, one result out.
// Optional build macro FIR_SAT_EN: wide accumulator with the result clamped to the signed data range.
module fir_mac_core #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tap_Num     = 11
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   clr,
  input  logic                   s_valid,
  input  logic [pDATA_WIDTH-1:0] s_data,
  input  logic                   s_last,
  output logic                   s_ready,
  output logic                   tap_ren,
  output logic [pADDR_WIDTH-1:0] tap_addr,
  input  logic [pDATA_WIDTH-1:0] tap_rdata,
  output logic                   y_valid,
  output logic [pDATA_WIDTH-1:0] y_data,
  output logic                   y_last,
  input  logic                   y_ready,
  output logic [31:0]            num_vld_ops,
  output logic                   busy
);

  localparam int KW = $clog2(Tap_Num + 1);
`ifdef FIR_SAT_EN
  localparam int AW = 2 * pDATA_WIDTH;
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-pDATA_WIDTH+1){1'b0}}, {(pDATA_WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-pDATA_WIDTH+1){1'b1}}, {(pDATA_WIDTH-1){1'b0}}};
`else
  localparam int AW = pDATA_WIDTH;
`endif

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                                  state, state_nxt;
  logic [KW-1:0]                           k;
  logic [Tap_Num-1:0][pDATA_WIDTH-1:0]     hist;
  logic signed [pDATA_WIDTH-1:0]           x_d, x_sel, coef, rd_hold;
  logic signed [AW-1:0]                    acc, prod;
  logic                                    last_q, en_q;
  logic                                    mac_rd, mac_add, mac_end;

  assign mac_rd  = (state == MAC) && (k < KW'(Tap_Num));
  assign mac_add = (state == MAC) && (k != '0);
  assign mac_end = (state == MAC) && (k == KW'(Tap_Num));

  // The tap SRAM keeps reading while ren is frozen high during a stall, so the
  // word that arrived from the last enabled read is held aside and reused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q    <= 1'b0;
      rd_hold <= '0;
    end else begin
      en_q <= en;
      if (en_q) rd_hold <= tap_rdata;
    end
  end

  assign coef = en_q ? tap_rdata : rd_hold;

  always_comb begin
    x_sel = '0;
    for (int i = 0; i < Tap_Num; i++)
      if (k == KW'(i)) x_sel = hist[i];
  end

`ifdef FIR_SAT_EN
  always_comb begin
    prod = $signed({{pDATA_WIDTH{coef[pDATA_WIDTH-1]}}, coef}) *
           $signed({{pDATA_WIDTH{x_d[pDATA_WIDTH-1]}}, x_d});
  end
`else
  // Low half of a signed product is the same as the unsigned one.
  always_comb prod = coef * x_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else if (en) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clr) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (s_valid) state_nxt = MAC;
        MAC:     if (mac_end) state_nxt = OUT;
        OUT:     if (y_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist        <= '0;
      acc         <= '0;
      k           <= '0;
      x_d         <= '0;
      last_q      <= 1'b0;
      num_vld_ops <= '0;
    end else if (en) begin
      if (clr) begin
        hist        <= '0;
        acc         <= '0;
        k           <= '0;
        num_vld_ops <= '0;
      end else begin
        case (state)
          IDLE: if (s_valid) begin
            hist   <= {hist[Tap_Num-2:0], s_data};
            last_q <= s_last;
            acc    <= '0;
            k      <= '0;
          end
          MAC: begin
            if (mac_rd)  x_d <= x_sel;
            if (mac_add) acc <= acc + prod;
            if (!mac_end) k <= k + KW'(1);
          end
          OUT: if (y_ready) num_vld_ops <= num_vld_ops + 32'd1;
          default: ;
        endcase
      end
    end
  end

  assign s_ready  = (state == IDLE) && en;
  assign tap_ren  = mac_rd;
  assign tap_addr = mac_rd ? pADDR_WIDTH'({k, 2'b00}) : '0;
  assign y_valid  = (state == OUT);
  assign y_last   = (state == OUT) && last_q;
  assign busy     = (state != IDLE);

  always_comb begin
    y_data = '0;
    if (state == OUT) begin
`ifdef FIR_SAT_EN
      if (acc > SAT_MAX)      y_data = SAT_MAX[pDATA_WIDTH-1:0];
      else if (acc < SAT_MIN) y_data = SAT_MIN[pDATA_WIDTH-1:0];
      else                    y_data = acc[pDATA_WIDTH-1:0];
`else
      y_data = acc;
`endif
    end
  end

endmodule

// File: tb/tb_fir_mac_core.sv
// Randomized bench for fir_mac_core against a plain-arithmetic FIR reference model.
module tb_fir_mac_core;
  localparam int AW = 12, DW = 32, NT = 11;

  logic          clk = 1'b0, rst_n = 1'b0, en = 1'b0, clr = 1'b0;
  logic          s_valid = 1'b0, s_last = 1'b0, y_ready = 1'b0;
  logic [DW-1:0] s_data = '0, tap_rdata = '0;
  logic          s_ready, tap_ren, y_valid, y_last, busy;
  logic [AW-1:0] tap_addr;
  logic [DW-1:0] y_data;
  logic [31:0]   num_vld_ops;

  fir_mac_core #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tap_Num(NT)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .tap_ren(tap_ren), .tap_addr(tap_addr), .tap_rdata(tap_rdata),
    .y_valid(y_valid), .y_data(y_data), .y_last(y_last), .y_ready(y_ready),
    .num_vld_ops(num_vld_ops), .busy(busy)
  );

  always #5 clk = ~clk;

  int            errors = 0, checks = 0;
  logic [31:0]   h [16];
  logic [31:0]   hist [$];
  logic [31:0]   exp_cnt = 0;
  logic [AW-1:0] max_addr = '0;

  // tap SRAM: registered read, one cycle latency
  always @(posedge clk) if (tap_ren) tap_rdata <= h[tap_addr[AW-1:2]];
  always @(negedge clk) if (tap_ren && tap_addr > max_addr) max_addr <= tap_addr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_y();
    longint s = 0;
    for (int i = 0; i < NT; i++) s += longint'($signed(h[i])) * longint'($signed(hist[i]));
`ifdef FIR_SAT_EN
    if (s > 64'sh7FFFFFFF) return 32'h7FFFFFFF;
    if (s < -64'sh80000000) return 32'h80000000;
`endif
    return s[31:0];
  endfunction

  task automatic model_clear();
    hist = {};
    repeat (NT) hist.push_back(32'd0);
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!s_ready && n < 40) begin @(negedge clk); n++; end
    chk("s_ready", s_ready, 1);
  endtask

  task automatic accept(input logic [31:0] x, input bit last);
    s_valid = 1'b1; s_data = x; s_last = last;
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
    hist.push_front(x);
    void'(hist.pop_back());
  endtask

  // One sample end to end: optional en stall mid-MAC and optional y_ready hold-off.
  task automatic run(input logic [31:0] x, input bit last, input int stall_at,
                     input int stall_len, input int hold);
    logic [31:0]   exp_y;
    logic [AW-1:0] sv_addr;
    logic          sv_ren;
    int            n = 0;
    wait_ready();
    accept(x, last);
    exp_y = ref_y();
    while (1) begin
      @(negedge clk); n++;
      if (y_valid || n >= 200) break;
      if (n == stall_at) begin
        en = 1'b0; sv_ren = tap_ren; sv_addr = tap_addr;
        repeat (stall_len) begin
          @(negedge clk); n++;
          chk("stall_ren", tap_ren, sv_ren);
          chk("stall_addr", tap_addr, sv_addr);
          chk("stall_srdy", s_ready, 0);
        end
        en = 1'b1;
      end
    end
    chk("latency", n, NT + 2 + stall_len);
    chk("y_data", y_data, exp_y);
    chk("y_last", y_last, last);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_vld", y_valid, 1);
      chk("hold_data", y_data, exp_y);
      chk("hold_srdy", s_ready, 0);
      chk("hold_cnt", num_vld_ops, exp_cnt);
    end
    y_ready = 1'b1;
    @(posedge clk); #1;
    y_ready = 1'b0;
    exp_cnt++;
    @(negedge clk);
    chk("y_fall", y_valid, 0);
    chk("count", num_vld_ops, exp_cnt);
    chk("idle", busy, 0);
  endtask

  initial begin
    model_clear();
    for (int i = 0; i < 16; i++) h[i] = (i < NT) ? 32'(i + 1) : 32'd0;
    en = 1'b1;
    #12;
    chk("rst_srdy", s_ready, 1);
    chk("rst_ren", tap_ren, 0);
    chk("rst_addr", tap_addr, 0);
    chk("rst_yv", y_valid, 0);
    chk("rst_yd", y_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", num_vld_ops, 0);
    @(negedge clk); rst_n = 1'b1;

    // impulse/ramp; third sample marks end of frame
    run(32'd1, 1'b0, 0, 0, 0);
    run(32'd2, 1'b0, 0, 0, 0);
    run(32'd3, 1'b1, 0, 0, 0);
    chk("ramp_last", ref_y(), 32'd10);
    chk("ramp_cnt", num_vld_ops, 3);

    // backpressure, then a stall mid-MAC
    run(32'd4, 1'b0, 0, 0, 20);
    run($urandom, 1'b0, 4, 5, 0);

    // clr in IDLE
    @(negedge clk); clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    model_clear(); exp_cnt = 0;
    @(negedge clk);
    chk("clr_cnt", num_vld_ops, 0);
    run(32'd5, 1'b0, 0, 0, 0);
    chk("clr_y5", y_data, 0);

    // wrap / saturate
    for (int i = 0; i < 16; i++) h[i] = 32'd0;
    h[0] = 32'h7FFFFFFF;
    run(32'd2, 1'b0, 0, 0, 0);
`ifdef FIR_SAT_EN
    chk("sat_ref", ref_y(), 32'h7FFFFFFF);
`else
    chk("wrap_ref", ref_y(), 32'hFFFFFFFE);
`endif

    // clr during MAC aborts without a result
    for (int i = 0; i < 16; i++) h[i] = (i < NT) ? 32'(i + 1) : 32'd0;
    wait_ready();
    accept(32'd9, 1'b0);
    repeat (3) @(negedge clk);
    clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    model_clear(); exp_cnt = 0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_yv", y_valid, 0);
    chk("abort_cnt", num_vld_ops, 0);

    // async reset in MAC cycle 4
    wait_ready();
    accept(32'd7, 1'b0);
    repeat (5) @(negedge clk);
    chk("mac4_addr", tap_addr, 16);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ren", tap_ren, 0);
    chk("arst_addr", tap_addr, 0);
    chk("arst_busy", busy, 0);
    chk("arst_yv", y_valid, 0);
    chk("arst_srdy", s_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    model_clear(); exp_cnt = 0;
    run(32'd1, 1'b0, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < NT; i++) h[i] = $urandom;
    for (int t = 0; t < 20; t++) begin
      int sa, sl;
      sa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 12)) : 0;
      sl = (sa != 0) ? int'($urandom_range(1, 4)) : 0;
      run($urandom, 1'($urandom_range(0, 1)), sa, sl, int'($urandom_range(0, 3)));
    end

    chk("addr_max", max_addr, (NT - 1) * 4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
